uart_rx_cmd_receiver: RTL and testbench

//  Serial receive end of the host RS232 link; the counterpart of the TxD transmit path.

---
 rtl/uart_rx_cmd_receiver.sv | 166 ++++++++++++++++
 tb/tb_uart_rx_cmd_receiver.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cmd_receiver.sv
// Host RS232 receive path: recovers 8N1 bytes (8E1 when RX_PARITY_EN is defined)
// from SDI and hands them to the command decoder over a valid/ack holding register.
module uart_rx_cmd_receiver #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       SDI,
    output logic [7:0] DataOut,
    output logic       DataValid,
    input  logic       DataAck,
    output logic       FramingError,
    output logic       OverrunError,
    output logic       ParityError
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4,
        PARITY    = 3'd5
    } rxState_t;
`else
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rxState_t;
`endif

    rxState_t               state;
    logic [SYNC_STAGES-1:0] syncReg;
    logic [CNT_W-1:0]       bitCnt;
    logic [2:0]             dataIdx;
    logic [7:0]             shiftReg;
    logic                   rxdS;

    assign rxdS = syncReg[SYNC_STAGES-1];

`ifdef RX_PARITY_EN
    logic parityBad;
`else
    assign ParityError = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            // Line may be mid-frame: resume only after it has been seen idle.
            syncReg      <= '1;
            state        <= WAIT_IDLE;
            bitCnt       <= '0;
            dataIdx      <= '0;
            shiftReg     <= '0;
            DataOut      <= '0;
            DataValid    <= 1'b0;
            FramingError <= 1'b0;
            OverrunError <= 1'b0;
`ifdef RX_PARITY_EN
            ParityError  <= 1'b0;
            parityBad    <= 1'b0;
`endif
        end else begin
            syncReg      <= {syncReg[SYNC_STAGES-2:0], SDI};
            FramingError <= 1'b0;
            OverrunError <= 1'b0;
`ifdef RX_PARITY_EN
            ParityError  <= 1'b0;
`endif
            if (DataAck && DataValid) begin
                DataValid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    bitCnt <= '0;
                    if (!rxdS) begin
                        state <= START;
                    end
                end
                START: begin
                    if (bitCnt == HALF_LAST) begin
                        bitCnt  <= '0;
                        dataIdx <= '0;
                        state   <= rxdS ? IDLE : DATA;
                    end else begin
                        bitCnt <= bitCnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bitCnt == FULL_LAST) begin
                        bitCnt   <= '0;
                        shiftReg <= {rxdS, shiftReg[7:1]};
                        if (dataIdx == 3'd7) begin
`ifdef RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            dataIdx <= dataIdx + 3'd1;
                        end
                    end else begin
                        bitCnt <= bitCnt + CNT_W'(1);
                    end
                end
`ifdef RX_PARITY_EN
                PARITY: begin
                    if (bitCnt == FULL_LAST) begin
                        bitCnt    <= '0;
                        parityBad <= (rxdS != (^shiftReg));
                        state     <= STOP;
                    end else begin
                        bitCnt <= bitCnt + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (bitCnt == FULL_LAST) begin
                        bitCnt <= '0;
                        if (!rxdS) begin
                            FramingError <= 1'b1;
                            state        <= WAIT_IDLE;
`ifdef RX_PARITY_EN
                        end else if (parityBad) begin
                            ParityError <= 1'b1;
                            state       <= IDLE;
`endif
                        end else begin
                            state <= IDLE;
                            // A same-cycle ack frees the holding register for this byte.
                            if (!DataValid || DataAck) begin
                                DataOut   <= shiftReg;
                                DataValid <= 1'b1;
                            end else begin
                                OverrunError <= 1'b1;
                            end
                        end
                    end else begin
                        bitCnt <= bitCnt + CNT_W'(1);
                    end
                end
                WAIT_IDLE: begin
                    bitCnt <= '0;
                    if (rxdS) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    bitCnt <= '0;
                    state  <= WAIT_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cmd_receiver.sv
// Self-checking bench for uart_rx_cmd_receiver: directed scenarios plus random frames
// compared against a frame-level model of the holding register and error pulses.
module tb_uart_rx_cmd_receiver;

    localparam int unsigned CPB  = 16;
    localparam int unsigned SYNC = 2;
`ifdef RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // Start edge -> DataValid: synchroniser, edge detect, half bit, then remaining bit times.
    localparam int COMMIT_LAT = SYNC + 1 + CPB / 2 + (FRAME_BITS - 1) * CPB;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       SDI = 1'b1;
    logic       DataAck = 1'b0;
    logic [7:0] DataOut;
    logic       DataValid;
    logic       FramingError;
    logic       OverrunError;
    logic       ParityError;

    int errors = 0;
    int checks = 0;
    int feCnt = 0, oeCnt = 0, peCnt = 0;
    int expFe = 0, expOe = 0, expPe = 0;
    logic       mValid = 1'b0;
    logic [7:0] mData = 8'h00;
`ifdef RX_PARITY_EN
    logic flipParity = 1'b0;
`endif

    uart_rx_cmd_receiver #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
        .Clock(Clock), .Reset(Reset), .SDI(SDI), .DataOut(DataOut), .DataValid(DataValid),
        .DataAck(DataAck), .FramingError(FramingError), .OverrunError(OverrunError),
        .ParityError(ParityError)
    );

    always #5 Clock = ~Clock;

    always @(negedge Clock) begin
        if (!Reset) begin
            if (FramingError) feCnt++;
            if (OverrunError) oeCnt++;
            if (ParityError)  peCnt++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        SDI = 1'b1;
        repeat (n) @(posedge Clock);
        #1;
    endtask

    // Drives one frame; riseAt = clocks from start edge to DataValid rising (0 if none).
    task automatic sendFrame(input logic [7:0] b, input logic stopBit, output int riseAt);
        logic [FRAME_BITS-1:0] frame;
        logic prevDv;
        int n;
`ifdef RX_PARITY_EN
        frame = {stopBit, (^b) ^ flipParity, b, 1'b0};
`else
        frame = {stopBit, b, 1'b0};
`endif
        riseAt = 0;
        prevDv = DataValid;
        n = 0;
        for (int i = 0; i < FRAME_BITS; i++) begin
            SDI = frame[i];
            repeat (CPB) begin
                @(posedge Clock);
                n++;
                #1;
                if (riseAt == 0 && DataValid && !prevDv) riseAt = n;
                prevDv = DataValid;
            end
        end
    endtask

    // Frame-level reference: returns 1 when the byte lands in an empty holding register.
    function automatic logic modelFrame(input logic [7:0] b, input logic stopOk, input logic parOk);
        if (!stopOk) begin
            expFe++;
            return 1'b0;
        end
        if (!parOk) begin
            expPe++;
            return 1'b0;
        end
        if (mValid) begin
            expOe++;
            return 1'b0;
        end
        mValid = 1'b1;
        mData  = b;
        return 1'b1;
    endfunction

    task automatic ackPulse();
        DataAck = 1'b1;
        @(posedge Clock);
        #1;
        DataAck = 1'b0;
        mValid = 1'b0;
    endtask

    task automatic checkState(input string name);
        checks++;
        if (DataValid !== mValid) begin
            errors++;
            $display("FAIL %s valid: got %b want %b", name, DataValid, mValid);
        end
        if (mValid) begin
            checks++;
            if (DataOut !== mData) begin
                errors++;
                $display("FAIL %s data: got %h want %h", name, DataOut, mData);
            end
        end
        checks++;
        if (feCnt !== expFe || oeCnt !== expOe || peCnt !== expPe) begin
            errors++;
            $display("FAIL %s pulses: got fe=%0d oe=%0d pe=%0d want fe=%0d oe=%0d pe=%0d",
                     name, feCnt, oeCnt, peCnt, expFe, expOe, expPe);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        Reset = 1'b0;
        @(posedge Clock);
        #1;
        checks++;
        if (DataOut !== 8'h00 || DataValid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got out=%h valid=%b want 00/0", DataOut, DataValid);
        end
        checks++;
        if (FramingError !== 1'b0 || OverrunError !== 1'b0 || ParityError !== 1'b0) begin
            errors++;
            $display("FAIL reset_errors: got %b%b%b want 000", FramingError, OverrunError, ParityError);
        end
    endtask

    task automatic test_basic();
        int rise;
        logic hit;
        idle(20);
        sendFrame(8'hA5, 1'b1, rise);
        hit = modelFrame(8'hA5, 1'b1, 1'b1);
        checks++;
        if (!hit || rise !== COMMIT_LAT) begin
            errors++;
            $display("FAIL basic_latency: got %0d want %0d", rise, COMMIT_LAT);
        end
        checkState("basic_A5");
        ackPulse();
        checkState("basic_ack");
    endtask

    task automatic test_glitch();
        int rise;
        SDI = 1'b0;
        repeat (4) @(posedge Clock);
        #1;
        idle(30);
        checkState("glitch_reject");
        sendFrame(8'h3C, 1'b1, rise);
        void'(modelFrame(8'h3C, 1'b1, 1'b1));
        checkState("glitch_then_3C");
        ackPulse();
    endtask

    task automatic test_framing();
        int rise;
        sendFrame(8'h3C, 1'b0, rise);
        void'(modelFrame(8'h3C, 1'b0, 1'b1));
        repeat (40) @(posedge Clock);
        #1;
        checkState("framing_pulse");
        idle(200);
        checkState("framing_no_false_start");
        sendFrame(8'h81, 1'b1, rise);
        void'(modelFrame(8'h81, 1'b1, 1'b1));
        checkState("framing_then_81");
        ackPulse();
    endtask

    task automatic test_back_to_back();
        int rise;
        idle(5);
        sendFrame(8'h11, 1'b1, rise);
        void'(modelFrame(8'h11, 1'b1, 1'b1));
        sendFrame(8'h22, 1'b1, rise);
        void'(modelFrame(8'h22, 1'b1, 1'b1));
        idle(5);
        checkState("overrun_hold_11");
        ackPulse();
    endtask

    task automatic test_reset_midframe();
        int rise;
        logic [7:0] b;
        sendFrame(8'hC3, 1'b1, rise);
        void'(modelFrame(8'hC3, 1'b1, 1'b1));
        b = 8'h5A;
        SDI = 1'b0;
        repeat (CPB) @(posedge Clock);
        for (int i = 0; i < 3; i++) begin
            SDI = b[i];
            repeat (CPB) @(posedge Clock);
        end
        SDI = b[3];
        repeat (CPB / 2) @(posedge Clock);
        #1;
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        mValid = 1'b0;
        checks++;
        if (DataOut !== 8'h00 || DataValid !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset: got out=%h valid=%b want 00/0", DataOut, DataValid);
        end
        idle(40);
        checkState("midframe_quiet");
        sendFrame(8'h5A, 1'b1, rise);
        void'(modelFrame(8'h5A, 1'b1, 1'b1));
        checkState("midframe_then_5A");
        ackPulse();
    endtask

    task automatic test_parity();
`ifdef RX_PARITY_EN
        int rise;
        flipParity = 1'b1;
        sendFrame(8'h07, 1'b1, rise);
        void'(modelFrame(8'h07, 1'b1, 1'b0));
        flipParity = 1'b0;
        idle(5);
        checkState("parity_bad_07");
        sendFrame(8'h07, 1'b1, rise);
        void'(modelFrame(8'h07, 1'b1, 1'b1));
        checkState("parity_good_07");
        ackPulse();
`else
        checks++;
        if (peCnt !== 0) begin
            errors++;
            $display("FAIL parity_tied: got %0d pulses want 0", peCnt);
        end
`endif
    endtask

    task automatic test_random();
        int rise;
        logic [7:0] b;
        logic stopOk, parOk, hit;
        for (int k = 0; k < 40; k++) begin
            b      = 8'($urandom);
            stopOk = ($urandom_range(0, 5) != 0);
            parOk  = 1'b1;
`ifdef RX_PARITY_EN
            parOk      = !(stopOk && $urandom_range(0, 5) == 0);
            flipParity = !parOk;
`endif
            sendFrame(b, stopOk, rise);
            hit = modelFrame(b, stopOk, parOk);
            if (!stopOk) begin
                repeat ($urandom_range(0, 30)) @(posedge Clock);
                #1;
                idle(4);
            end
            checks++;
            if (rise !== (hit ? COMMIT_LAT : 0)) begin
                errors++;
                $display("FAIL random_latency[%0d]: got %0d want %0d", k, rise, hit ? COMMIT_LAT : 0);
            end
            checkState("random_frame");
            if ($urandom_range(0, 1) == 1) ackPulse();
            idle($urandom_range(0, 20));
        end
`ifdef RX_PARITY_EN
        flipParity = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_reset_midframe();
        test_parity();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
